// File: rtl/cpu_pkg.sv
// Shared encodings for the MEM/WB boundary: writeback source select, load
// formats (funct3) and the datapath-width legality check.
package cpu_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_LINK = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    LF_LB  = 3'b000,
    LF_LH  = 3'b001,
    LF_LW  = 3'b010,
    LF_LD  = 3'b011,
    LF_LBU = 3'b100,
    LF_LHU = 3'b101,
    LF_LWU = 3'b110,
    LF_RSV = 3'b111
  } load_fmt_e;

  function automatic bit xlen_ok(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational load alignment and sign/zero extension. Lanes are chosen from
// the low address bits with the sub-lane bits ignored, so no misalignment trap.
module load_extract
  import cpu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0]  data_i,
  input  logic [2:0]       fmt_i,
  input  logic [OFF_W-1:0] off_i,
  output logic [XLEN-1:0]  data_o
);

  logic [OFF_W-1:0] off_h;
  logic [OFF_W-1:0] off_w;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [31:0]      word_v;
  logic [XLEN-1:0]  word_sx;
  logic [XLEN-1:0]  word_zx;

  assign off_h  = {off_i[OFF_W-1:1], 1'b0};
  assign off_w  = off_i & ~OFF_W'(3);
  assign byte_v = data_i[{off_i, 3'b000} +: 8];
  assign half_v = data_i[{off_h, 3'b000} +: 16];
  assign word_v = data_i[{off_w, 3'b000} +: 32];

  // On a 32-bit datapath the word lane is the whole register.
  generate
    if (XLEN == 64) begin : g_word64
      assign word_sx = {{32{word_v[31]}}, word_v};
      assign word_zx = {32'd0, word_v};
    end else begin : g_word32
      assign word_sx = word_v;
      assign word_zx = word_v;
    end
  endgenerate

  always_comb begin
    data_o = data_i;
    case (load_fmt_e'(fmt_i))
      LF_LB:   data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      LF_LH:   data_o = {{(XLEN-16){half_v[15]}}, half_v};
      LF_LW:   data_o = word_sx;
      LF_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_v};
      LF_LHU:  data_o = {{(XLEN-16){1'b0}}, half_v};
      LF_LWU:  data_o = word_zx;
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register: selects and extracts writeback data, drives the
// register-file write port and forwarding view, and counts retired instructions.
module mem_wb_pipe
  import cpu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       stall_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  input  logic                       reg_write_i,
  input  logic [1:0]                 wb_sel_i,
  input  logic [XLEN-1:0]            alu_data_i,
  input  logic [XLEN-1:0]            mem_data_i,
  input  logic [XLEN-1:0]            link_data_i,
  input  logic [2:0]                 load_fmt_i,
  input  logic [$clog2(XLEN/8)-1:0]  byte_off_i,
  input  logic [RA_W-1:0]            rd_i,
  output logic                       reg_write_o,
  output logic [RA_W-1:0]            reg_RDaddr_o,
  output logic [XLEN-1:0]            reg_RDdata_o,
  output logic [RA_W-1:0]            forwarding_rd_o,
  output logic                       fwd_valid_o,
  output logic [CNT_W-1:0]           retire_cnt_o
);

  generate
    if (!xlen_ok(XLEN)) begin : g_bad_xlen
      $error("mem_wb_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  logic [XLEN-1:0]  ld_data;
  logic [XLEN-1:0]  wb_data;

  logic             we_q,   we_d;
  logic [RA_W-1:0]  rd_q,   rd_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  load_extract #(
    .XLEN (XLEN)
  ) u_load_extract (
    .data_i (mem_data_i),
    .fmt_i  (load_fmt_i),
    .off_i  (byte_off_i),
    .data_o (ld_data)
  );

  // Reserved select falls back to the ALU result.
  always_comb begin
    wb_data = alu_data_i;
    case (wb_sel_e'(wb_sel_i))
      WB_MEM:  wb_data = ld_data;
      WB_LINK: wb_data = link_data_i;
      default: wb_data = alu_data_i;
    endcase
  end

  always_comb begin
    we_d   = we_q;
    rd_d   = rd_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      we_d   = 1'b0;
      rd_d   = '0;
      data_d = '0;
    end else if (!stall_i) begin
      // rd=0 never writes, but the instruction still retires.
      we_d   = reg_write_i & valid_i & (rd_i != '0);
      rd_d   = rd_i;
      data_d = wb_data;
      if (valid_i && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      we_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      we_q   <= we_d;
      rd_q   <= rd_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign reg_write_o     = we_q;
  assign fwd_valid_o     = we_q;
  assign reg_RDaddr_o    = rd_q;
  assign forwarding_rd_o = rd_q;
  assign reg_RDdata_o    = data_q;
  assign retire_cnt_o    = cnt_q;

endmodule
